// File: rtl/lzw_forward_dictionary_build_if.sv
// Bus bundle for the LZW forward dictionary builder: payload in, dictionary RAM port, code out.
// LZW_COLLISION_CNT_EN adds the collision counter to the bundle.
interface lzw_forward_dictionary_build_if;
  logic        dict_clr;
  logic [7:0]  data;
  logic        data_en;
  logic        data_last;
  logic        data_ready;
  logic [13:0] dictionary_addr;
  logic [22:0] dictionary_din;
  logic        dictionary_wren;
  logic [22:0] dictionary_dout;
  logic [13:0] compress_data;
  logic        compress_data_en;
  logic        compress_last;
  logic [13:0] dict_entry_cnt;
`ifdef LZW_COLLISION_CNT_EN
  logic [15:0] collision_cnt;

  modport slave (
    input  dict_clr, data, data_en, data_last, dictionary_dout,
    output data_ready, dictionary_addr, dictionary_din, dictionary_wren,
    output compress_data, compress_data_en, compress_last, dict_entry_cnt, collision_cnt
  );
  modport master (
    output dict_clr, data, data_en, data_last, dictionary_dout,
    input  data_ready, dictionary_addr, dictionary_din, dictionary_wren,
    input  compress_data, compress_data_en, compress_last, dict_entry_cnt, collision_cnt
  );
`else
  modport slave (
    input  dict_clr, data, data_en, data_last, dictionary_dout,
    output data_ready, dictionary_addr, dictionary_din, dictionary_wren,
    output compress_data, compress_data_en, compress_last, dict_entry_cnt
  );
  modport master (
    output dict_clr, data, data_en, data_last, dictionary_dout,
    input  data_ready, dictionary_addr, dictionary_din, dictionary_wren,
    input  compress_data, compress_data_en, compress_last, dict_entry_cnt
  );
`endif
endinterface

// File: rtl/lzw_forward_dictionary_build.sv
// LZW compressor core: hashes (prefix, byte) into an external dictionary RAM, extends or emits codes.
// Optional LZW_COLLISION_CNT_EN adds a saturating count of occupied-but-mismatching probes.
module lzw_forward_dictionary_build #(
  parameter int MAX_STR_LEN = 31,
  parameter int CODE_W      = 14
) (
  input  logic                           I_sys_clk,
  input  logic                           I_sys_rst_n,
  lzw_forward_dictionary_build_if.slave  bus
);

  localparam int                DIN_W    = CODE_W + 9;
  localparam logic [4:0]        MAX_LEN  = 5'(MAX_STR_LEN);
  localparam logic [CODE_W-1:0] DICT_CAP = CODE_W'((1 << CODE_W) - 256);
  localparam logic [CODE_W-1:0] FIRST_CODE = CODE_W'(256);

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_RD,
    ST_CMP,
    ST_FLUSH
  } state_t;

  state_t             state_reg;
  logic [CODE_W-1:0]  p_reg;
  logic [4:0]         len_reg;
  logic               open_reg;
  logic [7:0]         b_reg;
  logic               last_reg;
  logic [CODE_W-1:0]  clr_addr_reg;
  logic [CODE_W-1:0]  addr_reg;
  logic [DIN_W-1:0]   din_reg;
  logic               wren_reg;
  logic               ready_reg;
  logic [CODE_W-1:0]  code_reg;
  logic               code_en_reg;
  logic               code_last_reg;
  logic [CODE_W-1:0]  cnt_reg;
`ifdef LZW_COLLISION_CNT_EN
  logic [15:0]        coll_reg;
`endif

  logic [CODE_W-1:0]  hash_h;
  logic [CODE_W-1:0]  hash_addr;
  logic               entry_valid;
  logic               entry_hit;
  logic               len_ok;
  logic               dict_room;

  // Hashed slots are pushed out of the literal range 0..255 by forcing the top bit.
  always_comb begin
    hash_h      = p_reg ^ {bus.data, bus.data[5:0]};
    hash_addr   = (hash_h[CODE_W-1:8] == '0) ? {1'b1, hash_h[CODE_W-2:0]} : hash_h;
    entry_valid = bus.dictionary_dout[DIN_W-1];
    entry_hit   = (bus.dictionary_dout == {1'b1, p_reg, b_reg});
    len_ok      = (len_reg < MAX_LEN);
    dict_room   = (cnt_reg < DICT_CAP);
  end

  always_ff @(posedge I_sys_clk or negedge I_sys_rst_n) begin
    if (!I_sys_rst_n) begin
      state_reg     <= ST_CLEAR;
      p_reg         <= '0;
      len_reg       <= '0;
      open_reg      <= 1'b0;
      b_reg         <= '0;
      last_reg      <= 1'b0;
      clr_addr_reg  <= FIRST_CODE;
      addr_reg      <= '0;
      din_reg       <= '0;
      wren_reg      <= 1'b0;
      ready_reg     <= 1'b0;
      code_reg      <= '0;
      code_en_reg   <= 1'b0;
      code_last_reg <= 1'b0;
      cnt_reg       <= '0;
`ifdef LZW_COLLISION_CNT_EN
      coll_reg      <= '0;
`endif
    end else begin
      wren_reg      <= 1'b0;
      code_en_reg   <= 1'b0;
      code_last_reg <= 1'b0;
      case (state_reg)
        ST_CLEAR: begin
          wren_reg <= 1'b1;
          addr_reg <= clr_addr_reg;
          din_reg  <= '0;
          cnt_reg  <= '0;
`ifdef LZW_COLLISION_CNT_EN
          coll_reg <= '0;
`endif
          if (clr_addr_reg == '1) begin
            state_reg <= ST_IDLE;
            ready_reg <= 1'b1;
          end else begin
            clr_addr_reg <= clr_addr_reg + 1'b1;
          end
        end

        ST_IDLE: begin
          if (bus.data_en && ready_reg) begin
            if (!open_reg) begin
              p_reg    <= {{(CODE_W-8){1'b0}}, bus.data};
              len_reg  <= 5'd1;
              open_reg <= !bus.data_last;
              if (bus.data_last) begin
                code_reg      <= {{(CODE_W-8){1'b0}}, bus.data};
                code_en_reg   <= 1'b1;
                code_last_reg <= 1'b1;
              end
            end else begin
              b_reg     <= bus.data;
              last_reg  <= bus.data_last;
              addr_reg  <= hash_addr;
              ready_reg <= 1'b0;
              state_reg <= ST_RD;
            end
          end else if (bus.dict_clr && !open_reg) begin
            clr_addr_reg <= FIRST_CODE;
            ready_reg    <= 1'b0;
            state_reg    <= ST_CLEAR;
          end
        end

        ST_RD: state_reg <= ST_CMP;

        ST_CMP: begin
`ifdef LZW_COLLISION_CNT_EN
          if (entry_valid && !entry_hit && coll_reg != 16'hFFFF)
            coll_reg <= coll_reg + 16'd1;
`endif
          if (entry_hit && len_ok) begin
            p_reg     <= addr_reg;
            len_reg   <= len_reg + 5'd1;
            ready_reg <= 1'b1;
            state_reg <= ST_IDLE;
            if (last_reg) begin
              code_reg      <= addr_reg;
              code_en_reg   <= 1'b1;
              code_last_reg <= 1'b1;
              open_reg      <= 1'b0;
            end
          end else begin
            code_reg    <= p_reg;
            code_en_reg <= 1'b1;
            p_reg       <= {{(CODE_W-8){1'b0}}, b_reg};
            len_reg     <= 5'd1;
            // Only empty slots are claimed; collisions and over-long strings are never stored.
            if (!entry_valid && len_ok && dict_room) begin
              wren_reg <= 1'b1;
              din_reg  <= {1'b1, p_reg, b_reg};
              cnt_reg  <= cnt_reg + 1'b1;
            end
            if (last_reg) begin
              open_reg  <= 1'b0;
              state_reg <= ST_FLUSH;
            end else begin
              ready_reg <= 1'b1;
              state_reg <= ST_IDLE;
            end
          end
        end

        ST_FLUSH: begin
          code_reg      <= p_reg;
          code_en_reg   <= 1'b1;
          code_last_reg <= 1'b1;
          ready_reg     <= 1'b1;
          state_reg     <= ST_IDLE;
        end

        default: state_reg <= ST_CLEAR;
      endcase
    end
  end

  assign bus.data_ready       = ready_reg;
  assign bus.dictionary_addr  = addr_reg;
  assign bus.dictionary_din   = din_reg;
  assign bus.dictionary_wren  = wren_reg;
  assign bus.compress_data    = code_reg;
  assign bus.compress_data_en = code_en_reg;
  assign bus.compress_last    = code_last_reg;
  assign bus.dict_entry_cnt   = cnt_reg;
`ifdef LZW_COLLISION_CNT_EN
  assign bus.collision_cnt    = coll_reg;
`endif

endmodule

// File: tb/tb_lzw_forward_dictionary_build.sv
// Bench for lzw_forward_dictionary_build: registered-read RAM model, code scoreboard, vector table.
// Collision counter checks compile only with LZW_COLLISION_CNT_EN.
module tb_lzw_forward_dictionary_build;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lzw_forward_dictionary_build_if dif();

  lzw_forward_dictionary_build dut (
    .I_sys_clk   (clk),
    .I_sys_rst_n (rst_n),
    .bus         (dif)
  );

  typedef struct {
    logic [7:0]  b;
    logic        last;
    int          n;
    logic [13:0] c0;
    logic        l0;
    logic [13:0] c1;
    logic        l1;
  } vec_t;

  typedef struct {
    logic [13:0] code;
    logic        last;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        in_clear = 1'b0;
  logic        prop_mode = 1'b0;
  int          wr_cnt = 0;
  logic [13:0] wr_addr;
  logic [22:0] wr_din;
  int          byte_sum = 0;
  int          mon_len;

  logic [22:0] ram [0:16383];
  logic        bd_we = 1'b0;
  logic [13:0] bd_addr = '0;
  logic [22:0] bd_data = '0;

  // One-cycle registered-read RAM with a bench-side preload port.
  always @(posedge clk) begin
    if (dif.dictionary_wren) ram[dif.dictionary_addr] <= dif.dictionary_din;
    else if (bd_we)          ram[bd_addr] <= bd_data;
    dif.dictionary_dout <= ram[dif.dictionary_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] hash(input logic [13:0] p, input logic [7:0] b);
    logic [13:0] h;
    h = p ^ {b, b[5:0]};
    return (h[13:8] == 6'd0) ? {1'b1, h[12:0]} : h;
  endfunction

  function automatic int code_len(input logic [13:0] c);
    int n = 1;
    logic [13:0] x = c;
    for (int k = 0; k < 64 && x >= 14'd256; k++) begin
      x = ram[x][21:8];
      n++;
    end
    return n;
  endfunction

  always @(negedge clk) begin
    if (dif.dictionary_wren && !in_clear) begin
      wr_cnt++;
      wr_addr = dif.dictionary_addr;
      wr_din  = dif.dictionary_din;
      if (prop_mode) check("ins_len", 64'(code_len(dif.dictionary_din[21:8]) + 1 <= 31), 64'd1);
    end
    if (dif.compress_data_en) begin
      $display("code %04h last %0b", dif.compress_data, dif.compress_last);
      if (prop_mode) begin
        mon_len = code_len(dif.compress_data);
        byte_sum += mon_len;
        check("code_len", 64'(mon_len <= 31), 64'd1);
      end else if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_code: got %04h last %0b with nothing expected", dif.compress_data, dif.compress_last);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("code", {dif.compress_last, dif.compress_data}, {e.last, e.code});
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic last, input int n,
                      input logic [13:0] c0, input logic l0, input logic [13:0] c1, input logic l1);
    int t = 0;
    while (!dif.data_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("ready_timeout", dif.data_ready, 1);
    if (n > 0) sbq.push_back('{c0, l0});
    if (n > 1) sbq.push_back('{c1, l1});
    dif.data      = b;
    dif.data_last = last;
    dif.data_en   = 1'b1;
    @(negedge clk);
    dif.data_en   = 1'b0;
    dif.data_last = 1'b0;
  endtask

  task automatic drain(input string nm);
    repeat (8) @(negedge clk);
    check(nm, sbq.size(), 0);
  endtask

  task automatic poke(input logic [13:0] a, input logic [22:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  task automatic wait_clear();
    int t = 0;
    int bad = 0;
    in_clear = 1'b1;
    while (!dif.dictionary_wren && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("clr_start", dif.dictionary_wren, 1);
    for (int i = 0; i < 16128; i++) begin
      if (!dif.dictionary_wren || dif.dictionary_addr != 14'(256 + i) || dif.dictionary_din != 23'd0) bad++;
      if (dif.data_ready != (i == 16127)) bad++;
      @(negedge clk);
    end
    check("clr_walk", bad, 0);
    check("clr_end_wren", dif.dictionary_wren, 0);
    check("clr_ready", dif.data_ready, 1);
    check("clr_entry_cnt", dif.dict_entry_cnt, 0);
`ifdef LZW_COLLISION_CNT_EN
    check("clr_coll_cnt", dif.collision_cnt, 0);
`endif
    in_clear = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[12];
    logic [13:0] chain_p;
    logic [7:0]  cb;
    logic [7:0]  bseq[32];

    tbl[0]  = '{8'h41, 1'b0, 0, 14'h000, 1'b0, 14'h000, 1'b0};
    tbl[1]  = '{8'h42, 1'b0, 1, 14'h041, 1'b0, 14'h000, 1'b0};
    tbl[2]  = '{8'h41, 1'b0, 1, 14'h042, 1'b0, 14'h000, 1'b0};
    tbl[3]  = '{8'h42, 1'b1, 1, 14'h10C3, 1'b1, 14'h000, 1'b0};
    tbl[4]  = '{8'h55, 1'b1, 1, 14'h055, 1'b1, 14'h000, 1'b0};
    tbl[5]  = '{8'h7F, 1'b1, 1, 14'h07F, 1'b1, 14'h000, 1'b0};
    tbl[6]  = '{8'h41, 1'b0, 0, 14'h000, 1'b0, 14'h000, 1'b0};
    tbl[7]  = '{8'h42, 1'b1, 1, 14'h10C3, 1'b1, 14'h000, 1'b0};
    tbl[8]  = '{8'h42, 1'b0, 0, 14'h000, 1'b0, 14'h000, 1'b0};
    tbl[9]  = '{8'h41, 1'b0, 0, 14'h000, 1'b0, 14'h000, 1'b0};
    tbl[10] = '{8'h42, 1'b1, 2, 14'h1003, 1'b0, 14'h042, 1'b1};
    tbl[11] = '{8'h00, 1'b1, 1, 14'h000, 1'b1, 14'h000, 1'b0};

    dif.dict_clr  = 1'b0;
    dif.data      = '0;
    dif.data_en   = 1'b0;
    dif.data_last = 1'b0;

    // Reset state, then the post-reset dictionary sweep
    repeat (3) @(negedge clk);
    check("rst_ctl", {dif.data_ready, dif.dictionary_wren, dif.compress_data_en, dif.compress_last,
                      dif.dictionary_addr, dif.compress_data, dif.dict_entry_cnt}, '0);
    check("rst_din", dif.dictionary_din, 0);
    rst_n = 1'b1;
    wait_clear();

    // Two-byte frame into an empty dictionary
    wr_cnt = 0;
    send(8'h41, 1'b0, 0, 14'h0, 1'b0, 14'h0, 1'b0);
    send(8'h42, 1'b1, 2, 14'h041, 1'b0, 14'h042, 1'b1);
    drain("t2_drain");
    check("t2_wr_cnt", wr_cnt, 1);
    check("t2_wr_addr", wr_addr, 14'h10C3);
    check("t2_wr_din", wr_din, {1'b1, 14'h0041, 8'h42});
    check("t2_entry_cnt", dif.dict_entry_cnt, 1);

    // Occupied slot with a foreign entry: collision, no insert
    poke(14'h10C3, {1'b1, 14'h0005, 8'h07});
    wr_cnt = 0;
    send(8'h41, 1'b0, 0, 14'h0, 1'b0, 14'h0, 1'b0);
    send(8'h42, 1'b1, 2, 14'h041, 1'b0, 14'h042, 1'b1);
    drain("t4_drain");
    check("t4_wr_cnt", wr_cnt, 0);
    check("t4_entry_cnt", dif.dict_entry_cnt, 1);
`ifdef LZW_COLLISION_CNT_EN
    check("t4_coll_cnt", dif.collision_cnt, 1);
`endif

    // Reset while the second byte is in ST_RD
    send(8'h41, 1'b0, 0, 14'h0, 1'b0, 14'h0, 1'b0);
    dif.data    = 8'h42;
    dif.data_en = 1'b1;
    @(negedge clk);
    dif.data_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_async_ctl", {dif.data_ready, dif.dictionary_wren, dif.compress_data_en, dif.compress_last,
                           dif.dictionary_addr, dif.compress_data, dif.dict_entry_cnt}, '0);
    check("t6_async_din", dif.dictionary_din, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_clear();
    drain("t6_no_code");

    // Vector table on a freshly cleared dictionary
    for (int i = 0; i < 11; i++)
      send(tbl[i].b, tbl[i].last, tbl[i].n, tbl[i].c0, tbl[i].l0, tbl[i].c1, tbl[i].l1);
    drain("tbl_drain");
    check("tbl_entry_cnt", dif.dict_entry_cnt, 3);

    // Clear coinciding with an accept is dropped
    dif.dict_clr = 1'b1;
    send(8'h66, 1'b1, 1, 14'h066, 1'b1, 14'h0, 1'b0);
    dif.dict_clr = 1'b0;
    drain("clr_acc_drain");
    check("clr_acc_ready", dif.data_ready, 1);

    // Clear while a frame is open is ignored
    send(8'h55, 1'b0, 0, 14'h0, 1'b0, 14'h0, 1'b0);
    dif.dict_clr = 1'b1;
    @(negedge clk);
    dif.dict_clr = 1'b0;
    send(8'h55, 1'b1, 2, 14'h055, 1'b0, 14'h055, 1'b1);
    drain("clr_open_drain");
    check("clr_open_ready", dif.data_ready, 1);
    check("clr_open_cnt", dif.dict_entry_cnt, 4);

    // Explicit dictionary clear
    dif.dict_clr = 1'b1;
    @(negedge clk);
    dif.dict_clr = 1'b0;
    wait_clear();

    // Length limit: preload a 31-byte chain, then a 32nd byte must split without insert
    bseq[0] = 8'h10;
    chain_p = 14'h0010;
    for (int i = 1; i <= 30; i++) begin
      cb = 8'(i * 29 + 3);
      for (int k = 0; k < 256 && ram[hash(chain_p, cb)][22]; k++) cb = cb + 8'd1;
      bseq[i] = cb;
      poke(hash(chain_p, cb), {1'b1, chain_p, cb});
      chain_p = hash(chain_p, cb);
    end
    cb = 8'hA5;
    for (int k = 0; k < 256 && ram[hash(chain_p, cb)][22]; k++) cb = cb + 8'd1;
    bseq[31] = cb;
    wr_cnt = 0;
    for (int i = 0; i <= 30; i++) send(bseq[i], 1'b0, 0, 14'h0, 1'b0, 14'h0, 1'b0);
    send(bseq[31], 1'b1, 2, chain_p, 1'b0, {6'd0, bseq[31]}, 1'b1);
    drain("len_drain");
    check("len_no_insert", wr_cnt, 0);

    // Repeated zero frames: every emitted code stays within 31 bytes and frames reassemble
    prop_mode = 1'b1;
    for (int f = 0; f < 6; f++) begin
      byte_sum = 0;
      for (int i = 0; i < 40; i++) send(8'h00, 1'(i == 39), 0, 14'h0, 1'b0, 14'h0, 1'b0);
      repeat (8) @(negedge clk);
      check("t5_frame_bytes", byte_sum, 40);
    end
    prop_mode = 1'b0;

    // Single-byte literal frame after the run
    send(tbl[11].b, tbl[11].last, tbl[11].n, tbl[11].c0, tbl[11].l0, tbl[11].c1, tbl[11].l1);
    drain("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
